camera_capture_win: RTL
=======================

Name: camera_capture_win

Overview:
Second-generation camera (OV7725-class) parallel-port capture block, single clock domain.
- Oversamples the sensor pins (pclk, vsync, href, data) in HCLK.
- Applies a programmable X/Y crop window.
- Packs accepted pixel bytes into words and buffers them in a parametrised synchronous FIFO that the AHB DMA/slave side drains.
- Frames start and stop strictly on frame boundaries.
- Reports frame-start/frame-done pulses, item count and sticky overflow.

Parameters:
- DW, 8: sensor data bus width.
- PACK, 16: data beats packed per FIFO word; word width = DW*PACK.
- DEPTH, 8: FIFO entries, power of 2.
- AW, 3: log2(DEPTH).
- CNTW, 12: pixel/line counter and window register width.

Ports:
- HCLK, in, 1: system clock; must be at least 3x pclk frequency.
- HReset_N, in, 1: asynchronous active-low reset.
- pclk, in, 1: sensor pixel clock, sampled as data.
- vsync, in, 1: sensor frame sync.
- href, in, 1: sensor line valid.
- data, in, DW: sensor pixel data.
- HrefCtrl, in, 1: 1 means href is active-low.
- VsyncCtrl, in, 1: 1 means vsync is active-low.
- CaptureEn, in, 1: capture enable, honoured only at frame boundaries.
- i_XStart, in, CNTW: first accepted beat index in a line, inclusive.
- i_XEnd, in, CNTW: last accepted beat index in a line, inclusive.
- i_YStart, in, CNTW: first accepted line index, inclusive.
- i_YEnd, in, CNTW: last accepted line index, inclusive.
- i_ReadEn, in, 1: pop request.
- i_OvfClr, in, 1: clears sticky overflow.
- o_FIFOEmpty, out, 1: FIFO empty.
- o_RdData, out, DW*PACK: FIFO head word (show-ahead).
- o_ItemCnt, out, AW+1: FIFO occupancy.
- o_OverFlow, out, 1: sticky, set when a word was dropped.
- o_FrameStart, out, 1: 1-cycle pulse, capture of a frame begins.
- o_FrameDone, out, 1: 1-cycle pulse, captured frame ended.

Behaviour:

Reset values:
- All outputs reset to 0 except o_FIFOEmpty=1; o_RdData=0.
- FSM resets to IDLE; counters, pack register and FIFO pointers reset to 0.

Input sampling and edge detection:
- pclk, vsync, href and data each pass through a 2-flop synchroniser.
- Beat strobe = rising edge of synchronised pclk (sync2 & ~sync3); it samples the synchronised href/data of the same cycle.
- vs_act = vsync_s ^ VsyncCtrl; hr_act = href_s ^ HrefCtrl.
- Frame boundary FB = rising edge of vs_act.
- Line end = falling edge of hr_act.

FSM (IDLE, CAPT):
- IDLE: on FB with CaptureEn=1, go to CAPT, pulse o_FrameStart, and clear X, Y and the pack index.
- CAPT: on FB, pulse o_FrameDone (flush partial word per the optional feature).
  - CaptureEn=1: stay in CAPT, pulse o_FrameStart in the same cycle, clear X, Y and the pack index.
  - CaptureEn=0: go to IDLE.
- CaptureEn changes mid-frame have no effect until the next FB.

Counters:
- X increments on each beat strobe while hr_act, and clears at line end.
- Y increments at each line end, and clears at FB.
- Both saturate at 2^CNTW-1.
- A beat is accepted when all of the following hold: state CAPT, hr_act, beat strobe, XStart<=X<=XEnd, YStart<=Y<=YEnd.
- XStart>XEnd or YStart>YEnd means nothing is accepted.

Packing:
- Accepted beat k lands in bits [k*DW+DW-1 : k*DW], little-endian lanes.
- Pack index wraps PACK-1 -> 0.
- On the beat that fills lane PACK-1, the word is pushed to the FIFO in the next cycle.
- The pack index is not reset at line ends; it is reset only at FB.

FIFO:
- Push is accepted when not full, or when full with a simultaneous pop.
- A push while full without a pop drops the word and sets o_OverFlow.
- o_OverFlow clears only via i_OvfClr; if set and clear occur in the same cycle, set wins.
- Pop occurs when i_ReadEn & ~o_FIFOEmpty; i_ReadEn while empty is ignored.
- o_RdData is the head entry, valid whenever ~o_FIFOEmpty.
- o_ItemCnt: +1 on push only, -1 on pop only, unchanged on push and pop together. Range 0..DEPTH.
- Pointers are AW bits and wrap modulo DEPTH.

Latency:
- Pin edge to beat strobe: 3 HCLK.
- Last beat strobe of a word to o_FIFOEmpty falling: 2 HCLK.

Reset mid-frame: everything returns to reset values; FIFO contents are discarded.

Optional Feature:
CAM_PARTIAL_FLUSH_EN
- Defined: at FB while in CAPT with pack index != 0, the partial word is pushed with unfilled lanes zeroed, in the cycle after FB, under the normal full/overflow rules. o_FrameDone is then delayed to coincide with that push cycle.
- Undefined: the partial word is discarded at FB and o_FrameDone pulses in the FB cycle.

Test Plan:
1. Window 0..15 x 0..0, PACK=16, CaptureEn=1; one frame with one 32-beat line carrying bytes 0x00..0x1F -> exactly 1 word 0x0F0E..0100, o_ItemCnt=1, one o_FrameStart and one o_FrameDone.
2. HrefCtrl=1 and VsyncCtrl=1 with inverted sensor polarity, same stimulus as test 1 -> identical FIFO contents.
3. CaptureEn set mid-frame -> no words in the current frame, o_FrameStart at the next FB. CaptureEn cleared mid-frame -> the current frame completes, then IDLE.
4. No reads, 9 full words written with DEPTH=8 -> o_ItemCnt=8, o_OverFlow=1, the 9th word is lost. i_OvfClr clears the flag. Push and pop in the same cycle while full -> count stays 8, o_OverFlow unchanged.
5. 20 accepted beats then FB -> with CAM_PARTIAL_FLUSH_EN, 2 words, the second holding 4 data bytes and 12 zero bytes; without the macro, 1 word.
6. HReset_N asserted mid-line with 3 words queued -> o_FIFOEmpty=1, o_ItemCnt=0, FSM IDLE; the next frame captures cleanly.

Source files
------------

// File: rtl/camera_capture_win.sv
// camera_capture_win
//   Parallel-port camera capture for OV7725-class sensors, single HCLK domain.
//   Sensor pins are oversampled in HCLK, a programmable X/Y crop window selects
//   pixel beats, accepted beats are packed little-endian into DW*PACK-bit words
//   and queued in a show-ahead synchronous FIFO that the bus side drains.
//   Capture starts and stops only on frame boundaries.
//
//   Optional build macro: CAM_PARTIAL_FLUSH_EN
//     defined   - a partly filled word is pushed (zero padded) one cycle after
//                 the closing frame boundary; o_FrameDone coincides with it.
//     undefined - a partly filled word is discarded at the frame boundary.
//
// Ports
//   HCLK, HReset_N        system clock, asynchronous active-low reset
//   pclk, vsync, href     raw sensor timing pins (sampled as data)
//   data[DW]              raw sensor pixel bus
//   HrefCtrl, VsyncCtrl   1 = corresponding sensor signal is active-low
//   CaptureEn             capture request, honoured at frame boundaries
//   i_XStart..i_YEnd      inclusive crop window (beat index / line index)
//   i_ReadEn              FIFO pop request
//   i_OvfClr              clear sticky overflow
//   o_FIFOEmpty           FIFO empty
//   o_RdData[DW*PACK]     FIFO head word, zero while empty
//   o_ItemCnt[AW+1]       FIFO occupancy 0..DEPTH
//   o_OverFlow            sticky: a packed word was dropped
//   o_FrameStart          1-cycle pulse, capture of a frame begins
//   o_FrameDone           1-cycle pulse, captured frame ended
module camera_capture_win #(
    parameter int DW    = 8,
    parameter int PACK  = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int CNTW  = 12
) (
    input  logic               HCLK,
    input  logic               HReset_N,
    input  logic               pclk,
    input  logic               vsync,
    input  logic               href,
    input  logic [DW-1:0]      data,
    input  logic               HrefCtrl,
    input  logic               VsyncCtrl,
    input  logic               CaptureEn,
    input  logic [CNTW-1:0]    i_XStart,
    input  logic [CNTW-1:0]    i_XEnd,
    input  logic [CNTW-1:0]    i_YStart,
    input  logic [CNTW-1:0]    i_YEnd,
    input  logic               i_ReadEn,
    input  logic               i_OvfClr,
    output logic               o_FIFOEmpty,
    output logic [DW*PACK-1:0] o_RdData,
    output logic [AW:0]        o_ItemCnt,
    output logic               o_OverFlow,
    output logic               o_FrameStart,
    output logic               o_FrameDone
);

    localparam int WW = DW * PACK;
    localparam int PW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [PW-1:0] LAST_LANE = PW'(PACK - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

    typedef enum logic {IDLE, CAPT} state_t;

    // ---------------- input synchronisers ----------------
    // Stage [2] is only used for edge detection. vsync/href edges compare
    // stage [1] against stage [2] after the polarity XOR, so reset (all
    // stages zero) never manufactures an edge whatever the polarity setting.
    logic [2:0]    pclk_sync, vs_sync, hr_sync;
    logic [DW-1:0] data_m, data_s;

    always_ff @(posedge HCLK or negedge HReset_N) begin
        if (!HReset_N) begin
            pclk_sync <= '0;
            vs_sync   <= '0;
            hr_sync   <= '0;
            data_m    <= '0;
            data_s    <= '0;
        end else begin
            pclk_sync <= {pclk_sync[1:0], pclk};
            vs_sync   <= {vs_sync[1:0], vsync};
            hr_sync   <= {hr_sync[1:0], href};
            data_m    <= data;
            data_s    <= data_m;
        end
    end

    logic strobe, vs_act, vs_prev, hr_act, hr_prev, fb, line_end;

    assign strobe   = pclk_sync[1] & ~pclk_sync[2];
    assign vs_act   = vs_sync[1] ^ VsyncCtrl;
    assign vs_prev  = vs_sync[2] ^ VsyncCtrl;
    assign hr_act   = hr_sync[1] ^ HrefCtrl;
    assign hr_prev  = hr_sync[2] ^ HrefCtrl;
    assign fb       = vs_act & ~vs_prev;
    assign line_end = hr_prev & ~hr_act;

    // ---------------- frame FSM ----------------
    state_t state, state_next;

    always_ff @(posedge HCLK or negedge HReset_N) begin
        if (!HReset_N) state <= IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next   = state;
        o_FrameStart = 1'b0;
        if (fb) begin
            case (state)
                IDLE: begin
                    if (CaptureEn) begin
                        state_next   = CAPT;
                        o_FrameStart = 1'b1;
                    end
                end
                CAPT: begin
                    if (CaptureEn) o_FrameStart = 1'b1;
                    else           state_next   = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // ---------------- beat / line counters ----------------
    logic [CNTW-1:0] x_cnt, y_cnt;

    always_ff @(posedge HCLK or negedge HReset_N) begin
        if (!HReset_N) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            if (fb || line_end)
                x_cnt <= '0;
            else if (strobe && hr_act && x_cnt != '1)
                x_cnt <= x_cnt + 1'b1;

            if (fb)
                y_cnt <= '0;
            else if (line_end && y_cnt != '1)
                y_cnt <= y_cnt + 1'b1;
        end
    end

    logic in_win, accept;

    // An inverted range (start > end) can never satisfy both bounds.
    assign in_win = (x_cnt >= i_XStart) && (x_cnt <= i_XEnd) &&
                    (y_cnt >= i_YStart) && (y_cnt <= i_YEnd);
    // The frame boundary takes precedence over a coincident beat.
    assign accept = (state == CAPT) && hr_act && strobe && in_win && !fb;

    // ---------------- packing ----------------
    // Lanes not yet written stay zero, so a flushed partial word is
    // already padded without extra masking.
    logic [PW-1:0] pack_idx;
    logic [WW-1:0] pack_reg, pack_next, word_q;
    logic          push_q;
`ifdef CAM_PARTIAL_FLUSH_EN
    logic          flush_q;
`endif

    always_comb begin
        pack_next = pack_reg;
        pack_next[int'(pack_idx) * DW +: DW] = data_s;
    end

    always_ff @(posedge HCLK or negedge HReset_N) begin
        if (!HReset_N) begin
            pack_idx <= '0;
            pack_reg <= '0;
            word_q   <= '0;
            push_q   <= 1'b0;
`ifdef CAM_PARTIAL_FLUSH_EN
            flush_q  <= 1'b0;
`endif
        end else begin
            push_q <= 1'b0;
`ifdef CAM_PARTIAL_FLUSH_EN
            flush_q <= 1'b0;
`endif
            if (fb) begin
`ifdef CAM_PARTIAL_FLUSH_EN
                if (state == CAPT && pack_idx != '0) begin
                    word_q  <= pack_reg;
                    push_q  <= 1'b1;
                    flush_q <= 1'b1;
                end
`endif
                pack_idx <= '0;
                pack_reg <= '0;
            end else if (accept) begin
                if (pack_idx == LAST_LANE) begin
                    word_q   <= pack_next;
                    push_q   <= 1'b1;
                    pack_idx <= '0;
                    pack_reg <= '0;
                end else begin
                    pack_idx <= pack_idx + 1'b1;
                    pack_reg <= pack_next;
                end
            end
        end
    end

`ifdef CAM_PARTIAL_FLUSH_EN
    assign o_FrameDone = (fb && state == CAPT && pack_idx == '0) || flush_q;
`else
    assign o_FrameDone = fb && (state == CAPT);
`endif

    // ---------------- show-ahead FIFO ----------------
    logic [WW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop, wr_ok;

    assign full        = (count == FULL_CNT);
    assign o_FIFOEmpty = (count == '0);
    assign pop         = i_ReadEn & ~o_FIFOEmpty;
    assign wr_ok       = push_q & (~full | pop);
    assign o_ItemCnt   = count;
    assign o_RdData    = o_FIFOEmpty ? '0 : mem[rd_ptr];

    always_ff @(posedge HCLK) begin
        if (wr_ok) mem[wr_ptr] <= word_q;
    end

    always_ff @(posedge HCLK or negedge HReset_N) begin
        if (!HReset_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_OverFlow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (wr_ok && !pop)      count <= count + 1'b1;
            else if (!wr_ok && pop) count <= count - 1'b1;

            if (push_q && full && !pop) o_OverFlow <= 1'b1;
            else if (i_OvfClr)          o_OverFlow <= 1'b0;
        end
    end

endmodule
